// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : RV32I ALU encoding constants shared by the ALU-control
//                decoder and the instruction encoder, so that both sides agree
//                on every code.
//                Contents: ALU control codes (ALU_ADD..ALU_SLT), the R-type and
//                I-type ALU opcodes, and the funct3/funct7 field values.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    // 3-bit ALU control codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Major opcodes for register-register and register-immediate ALU ops
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;

    // funct3 values (add and sub share a funct3; funct7 tells them apart)
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // funct7 values
    localparam logic [6:0] F7_NORMAL = 7'b0000000;
    localparam logic [6:0] F7_SUB    = 7'b0100000;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/alu_instr_pack.sv
`default_nettype none
// ============================================================================
//  Module      : alu_instr_pack
//  Description : Purely combinational mapping from an ALU request to the
//                RV32I word that decodes back to the same ALU control code.
//                Ports:
//                  i_alu_ctrl  3-bit ALU control code
//                  i_use_imm   1 = I-type, 0 = R-type
//                  i_rd/i_rs1/i_rs2  register indices (rs2 unused for I-type)
//                  i_imm       12-bit I-type immediate
//                  o_word      encoded instruction word
//                  o_illegal   request has no legal encoding
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_instr_pack
    import riscv_pkg::*;
(
    input  logic [2:0]  i_alu_ctrl,
    input  logic        i_use_imm,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [11:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_illegal
);

    logic [2:0] w_funct3;
    logic [6:0] w_funct7;

    always_comb begin
        w_funct3  = F3_ADD_SUB;
        w_funct7  = F7_NORMAL;
        o_illegal = 1'b0;
        case (i_alu_ctrl)
            ALU_ADD: w_funct3 = F3_ADD_SUB;
            ALU_SUB: begin
                w_funct3 = F3_ADD_SUB;
                w_funct7 = F7_SUB;
                // There is no subi in RV32I
                o_illegal = i_use_imm;
            end
            ALU_AND: w_funct3 = F3_AND;
            ALU_OR:  w_funct3 = F3_OR;
            ALU_XOR: w_funct3 = F3_XOR;
            ALU_SLT: w_funct3 = F3_SLT;
            default: o_illegal = 1'b1;
        endcase

        if (i_use_imm) begin
            o_word = {i_imm, i_rs1, w_funct3, i_rd, OP_ITYPE};
        end else begin
            o_word = {w_funct7, i_rs2, i_rs1, w_funct3, i_rd, OP_RTYPE};
        end
    end

endmodule : alu_instr_pack
`default_nettype wire

// File: rtl/alu_instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : alu_instr_encoder
//  Description : Streams encoded RV32I ALU instructions into instruction
//                memory. A start command programs base address and word
//                count; requests arrive on a valid/ready handshake and leave
//                through a one-deep registered write stage with back-pressure.
//                Ports:
//                  clk, reset (async, active-high)
//                  start, base_addr, length       transfer command
//                  in_valid/in_ready, in_*         request channel
//                  mem_we/mem_addr/mem_wdata,
//                  mem_ready                      memory write port
//                  busy, done, err_count          status
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_instr_encoder
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_alu_ctrl,
    input  logic              in_use_imm,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [11:0]       in_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic [7:0]        err_count
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_addr;      // address of the next word to complete
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_acc;       // legal requests accepted
    logic [LEN_W-1:0]  r_wr;        // writes completed
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic [7:0]        r_err;

    logic [31:0]       w_word;
    logic              w_illegal;
    logic              w_run;
    logic              w_start_ok;
    logic              w_drain;
    logic              w_accept;
    logic              w_last_write;

    alu_instr_pack u_pack (
        .i_alu_ctrl (in_alu_ctrl),
        .i_use_imm  (in_use_imm),
        .i_rd       (in_rd),
        .i_rs1      (in_rs1),
        .i_rs2      (in_rs2),
        .i_imm      (in_imm),
        .o_word     (w_word),
        .o_illegal  (w_illegal)
    );

    assign w_run        = (r_state == c_st_run);
    assign w_start_ok   = start && !w_run;
    assign w_drain      = r_mem_we && mem_ready;
    assign in_ready     = w_run && (r_acc < r_len) && (!r_mem_we || mem_ready);
    assign w_accept     = in_valid && in_ready;
    // In RUN length is at least 1, so length-1 cannot underflow
    assign w_last_write = (r_wr == (r_len - LEN_W'(1)));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle, c_st_done: begin
                if (start) begin
                    w_state_nxt = (length == '0) ? c_st_done : c_st_run;
                end
            end
            c_st_run: begin
                if (w_drain && w_last_write) begin
                    w_state_nxt = c_st_done;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr      <= '0;
            r_len       <= '0;
            r_acc       <= '0;
            r_wr        <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_err       <= '0;
        end else begin
            if (w_start_ok) begin
                // Low two address bits are forced to zero (word aligned)
                r_addr <= base_addr & ~ADDR_W'(3);
                r_len  <= length;
                r_acc  <= '0;
                r_wr   <= '0;
            end else begin
                if (w_drain) begin
                    r_addr <= r_addr + ADDR_W'(4);
                    r_wr   <= r_wr + LEN_W'(1);
                end
                if (w_accept && !w_illegal) begin
                    r_acc <= r_acc + LEN_W'(1);
                end
            end

            if (w_accept && !w_illegal) begin
                r_mem_we    <= 1'b1;
                r_mem_wdata <= w_word;
                // If the pending word drains this cycle, the new one follows it
                r_mem_addr  <= w_drain ? (r_addr + ADDR_W'(4)) : r_addr;
            end else if (w_drain) begin
                r_mem_we <= 1'b0;
            end

            if (w_accept && w_illegal && (r_err != 8'hFF)) begin
                r_err <= r_err + 8'd1;
            end
        end
    end

    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = w_run;
    assign done      = (r_state == c_st_done);
    assign err_count = r_err;

endmodule : alu_instr_encoder
`default_nettype wire

// File: tb/tb_alu_instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_instr_encoder
//  Description : Scoreboard testbench for alu_instr_encoder. Expected
//                {address, word} pairs are queued when a request is accepted;
//                a monitor pops and compares on every completed write.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] base_addr;
    logic [7:0]  length;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_alu_ctrl;
    logic        in_use_imm;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [11:0] in_imm;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        busy;
    logic        done;
    logic [7:0]  err_count;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] sb_q[$];
    logic [31:0] exp_addr;

    alu_instr_encoder #(.ADDR_W(32), .LEN_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .length     (length),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_alu_ctrl(in_alu_ctrl),
        .in_use_imm (in_use_imm),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_imm     (in_imm),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .busy       (busy),
        .done       (done),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every completed write must match the head of the scoreboard
    always @(negedge clk) begin
        if (!reset && mem_we && mem_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got %h @%h expected no write", mem_wdata, mem_addr);
            end else begin
                logic [63:0] e;
                e = sb_q.pop_front();
                chk("write_addr", mem_addr, e[63:32]);
                chk("write_data", mem_wdata, e[31:0]);
            end
        end
    end

    task automatic do_start(input logic [31:0] base, input logic [7:0] len);
        @(negedge clk);
        start     = 1'b1;
        base_addr = base;
        length    = len;
        @(negedge clk);
        start     = 1'b0;
        exp_addr  = base & 32'hFFFF_FFFC;
    endtask

    // Issue one request; legal ones push their expected write on acceptance
    task automatic send(input logic [2:0] ctrl, input logic imm_sel, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm,
                        input logic legal, input logic [31:0] exp_word);
        int n;
        @(negedge clk);
        in_valid    = 1'b1;
        in_alu_ctrl = ctrl;
        in_use_imm  = imm_sel;
        in_rd       = rd;
        in_rs1      = rs1;
        in_rs2      = rs2;
        in_imm      = imm;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            if (legal) begin
                sb_q.push_back({exp_addr, exp_word});
                exp_addr = exp_addr + 32'd4;
            end
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("done_reached", 32'(done), 32'd1);
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("in_ready_after_done", 32'(in_ready), 32'd0);
    endtask

    task automatic set_mem_ready(input logic v);
        @(posedge clk);
        #1 mem_ready = v;
    endtask

    task automatic chk_reset_state();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = '0; length = '0;
        in_valid = 1'b0; in_alu_ctrl = '0; in_use_imm = 1'b0;
        in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        mem_ready = 1'b1; exp_addr = '0;
        repeat (3) @(negedge clk);
        chk_reset_state();
        reset = 1'b0;

        // Single add
        do_start(32'h100, 8'd1);
        chk("busy_in_run", 32'(busy), 32'd1);
        send(3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 12'h0, 1'b1, 32'h002081B3);
        wait_done();

        // sub then slt
        do_start(32'h100, 8'd2);
        send(3'b001, 1'b0, 5'd3, 5'd1, 5'd2, 12'h0, 1'b1, 32'h402081B3);
        send(3'b101, 1'b0, 5'd4, 5'd2, 5'd3, 12'h0, 1'b1, 32'h00312233);
        wait_done();

        // I-type, unaligned base (low bits dropped)
        do_start(32'h203, 8'd2);
        send(3'b000, 1'b1, 5'd5, 5'd0, 5'd7, 12'hFFF, 1'b1, 32'hFFF00293);
        send(3'b010, 1'b1, 5'd1, 5'd1, 5'd0, 12'h00F, 1'b1, 32'h00F0F093);
        wait_done();

        // Illegal requests interleaved with two legal ones
        do_start(32'h300, 8'd2);
        send(3'b110, 1'b0, 5'd1, 5'd1, 5'd1, 12'h0, 1'b0, 32'h0);
        send(3'b011, 1'b0, 5'd6, 5'd7, 5'd8, 12'h0, 1'b1, 32'h0083E333);
        send(3'b111, 1'b1, 5'd1, 5'd1, 5'd1, 12'h1, 1'b0, 32'h0);
        send(3'b001, 1'b1, 5'd2, 5'd2, 5'd2, 12'h5, 1'b0, 32'h0);
        send(3'b100, 1'b1, 5'd9, 5'd10, 5'd0, 12'h0AA, 1'b1, 32'h0AA54493);
        wait_done();
        chk("err_count_3", 32'(err_count), 32'd3);

        // Back-pressure: first word stalls 5 cycles, then back-to-back drain
        set_mem_ready(1'b0);
        do_start(32'h400, 8'd3);
        chk("err_kept_on_start", 32'(err_count), 32'd3);
        send(3'b101, 1'b1, 5'd2, 5'd3, 5'd0, 12'h001, 1'b1, 32'h0011A113);
        fork
            begin
                send(3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 12'h0, 1'b1, 32'h002081B3);
                send(3'b001, 1'b0, 5'd3, 5'd1, 5'd2, 12'h0, 1'b1, 32'h402081B3);
            end
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("stall_we", 32'(mem_we), 32'd1);
                    chk("stall_addr", mem_addr, 32'h400);
                    chk("stall_data", mem_wdata, 32'h0011A113);
                    chk("stall_in_ready", 32'(in_ready), 32'd0);
                end
                set_mem_ready(1'b1);
            end
        join
        wait_done();

        // Address wraps past the top of the address space
        do_start(32'hFFFF_FFFC, 8'd2);
        send(3'b011, 1'b0, 5'd6, 5'd7, 5'd8, 12'h0, 1'b1, 32'h0083E333);
        send(3'b100, 1'b1, 5'd9, 5'd10, 5'd0, 12'h0AA, 1'b1, 32'h0AA54493);
        wait_done();
        chk("sb_empty_before_reset", 32'(sb_q.size()), 32'd0);

        // Reset with a stalled word drops it
        set_mem_ready(1'b0);
        do_start(32'h500, 8'd2);
        send(3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 12'h0, 1'b1, 32'h002081B3);
        @(negedge clk);
        chk("pre_reset_we", 32'(mem_we), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk_reset_state();
        sb_q.delete();
        @(negedge clk);
        reset = 1'b0;
        mem_ready = 1'b1;

        // Zero-length start goes straight to DONE without writing
        do_start(32'h600, 8'd0);
        chk("len0_done", 32'(done), 32'd1);
        chk("len0_busy", 32'(busy), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("len0_no_write", 32'(mem_we), 32'd0);
        end
        chk("sb_empty_end", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_alu_instr_encoder
`default_nettype wire
